// File: rtl/knn_pkg.sv
// Shared types for the KNN result stream packer.
// FSM encoding and the fixed result-index width.
package knn_pkg;
  localparam int NAME_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_NAME  = 2'd1,
    SEND_VALUE = 2'd2
  } state_t;
endpackage

// File: rtl/knn_result_fifo.sv
// Result-pair FIFO; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module knn_result_fifo
  import knn_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rd_ptr];

  // Storage is left unreset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/knn_result_axis_packer.sv
// Packs {index, distance} results into a two-beat AXI
// stream per result, with TLAST closing each K-result frame.
module knn_result_axis_packer
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  AXIS_out_wr_en,
  input  logic [NAME_W-1:0]     dataNameOut,
  input  logic [DATA_WIDTH-1:0] dataValueOut,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NAME_W + DATA_WIDTH;
  localparam logic [7:0] KM1 = 8'(K - 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t                state;
  logic [7:0]            cnt;
  logic [PW-1:0]         head;
  logic [NAME_W-1:0]     head_name;
  logic [DATA_WIDTH-1:0] head_val;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;
  logic                  pop;

  assign pop       = (state == SEND_VALUE) && M_AXIS_TREADY;
  assign head_name = head[PW-1 -: NAME_W];
  assign head_val  = head[DATA_WIDTH-1:0];

  knn_result_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst   (reset),
    .push  (AXIS_out_wr_en),
    .pop   (pop),
    .din   ({dataNameOut, dataValueOut}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (AXIS_out_wr_en && full && !pop) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) state <= SEND_NAME;
        end
        SEND_NAME: begin
          if (M_AXIS_TREADY) state <= SEND_VALUE;
        end
        SEND_VALUE: begin
          if (M_AXIS_TREADY) begin
            state <= (count > ONE) ? SEND_NAME : IDLE;
            cnt   <= (cnt == KM1) ? 8'd0 : cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXIS_TVALID = (state != IDLE);
  assign M_AXIS_TLAST  = (state == SEND_VALUE) && (cnt == KM1);

  always_comb begin
    M_AXIS_TDATA = '0;
    unique case (state)
      SEND_NAME:  M_AXIS_TDATA = head_name;
      SEND_VALUE: M_AXIS_TDATA = 32'(head_val);
      default:    M_AXIS_TDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_knn_result_axis_packer.sv
// Directed bench for the KNN result stream packer.
// Instance a: 16-bit values, K=2, depth 4; b/c: K=3 and K=1.
module tb_knn_result_axis_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_wr = 1'b0;
  logic [31:0] a_name = '0;
  logic [15:0] a_val = '0;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_ready = 1'b0;
  logic        a_tlast;
  logic        a_ovf;

  logic        b_wr = 1'b0;
  logic [31:0] b_name = '0;
  logic [31:0] b_val = '0;
  logic        b_ready = 1'b0;
  logic [31:0] b_tdata;
  logic        b_tvalid;
  logic        b_tlast;
  logic        b_ovf;
  logic [31:0] c_tdata;
  logic        c_tvalid;
  logic        c_tlast;
  logic        c_ovf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  knn_result_axis_packer #(
    .DATA_WIDTH (16), .K (2), .FIFO_DEPTH (4)
  ) ua (
    .mclk (clk), .reset (rst),
    .AXIS_out_wr_en (a_wr), .dataNameOut (a_name),
    .dataValueOut (a_val), .M_AXIS_TDATA (a_tdata),
    .M_AXIS_TVALID (a_tvalid), .M_AXIS_TREADY (a_ready),
    .M_AXIS_TLAST (a_tlast), .overflow (a_ovf)
  );

  knn_result_axis_packer #(
    .DATA_WIDTH (32), .K (3), .FIFO_DEPTH (8)
  ) ub (
    .mclk (clk), .reset (rst),
    .AXIS_out_wr_en (b_wr), .dataNameOut (b_name),
    .dataValueOut (b_val), .M_AXIS_TDATA (b_tdata),
    .M_AXIS_TVALID (b_tvalid), .M_AXIS_TREADY (b_ready),
    .M_AXIS_TLAST (b_tlast), .overflow (b_ovf)
  );

  knn_result_axis_packer #(
    .DATA_WIDTH (32), .K (1), .FIFO_DEPTH (8)
  ) uc (
    .mclk (clk), .reset (rst),
    .AXIS_out_wr_en (b_wr), .dataNameOut (b_name),
    .dataValueOut (b_val), .M_AXIS_TDATA (c_tdata),
    .M_AXIS_TVALID (c_tvalid), .M_AXIS_TREADY (b_ready),
    .M_AXIS_TLAST (c_tlast), .overflow (c_ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic a_push(input logic [31:0] n,
                        input logic [15:0] v);
    a_wr = 1'b1; a_name = n; a_val = v;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] n,
                        input logic [31:0] v);
    b_wr = 1'b1; b_name = n; b_val = v;
    tick();
    b_wr = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_tvalid", 32'(a_tvalid), 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tlast", 32'(a_tlast), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    tick();
    tick();
    rst = 1'b0;

    // basic frame
    a_ready = 1'b1;
    a_push(5, 16'h10);
    chk("basic_lat1", 32'(a_tvalid), 0);
    a_push(9, 16'h20);
    chk("basic_lat2", 32'(a_tvalid), 1);
    chk("basic_n0", a_tdata, 5);
    chk("basic_l0", 32'(a_tlast), 0);
    tick();
    chk("basic_v0", a_tdata, 32'h10);
    chk("basic_l1", 32'(a_tlast), 0);
    tick();
    chk("basic_n1", a_tdata, 9);
    chk("basic_l2", 32'(a_tlast), 0);
    tick();
    chk("basic_v1", a_tdata, 32'h20);
    chk("basic_l3", 32'(a_tlast), 1);
    tick();
    chk("basic_idle", 32'(a_tvalid), 0);

    // backpressure on a name beat
    a_ready = 1'b0;
    a_push(7, 16'h77);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(a_tvalid), 1);
      chk("bp_data", a_tdata, 7);
      tick();
    end
    a_ready = 1'b1;
    chk("bp_name", a_tdata, 7);
    tick();
    chk("bp_val", a_tdata, 32'h77);
    chk("bp_last", 32'(a_tlast), 0);
    tick();
    chk("bp_idle", 32'(a_tvalid), 0);

    // overflow at depth 4
    do_rst();
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_push(32'(i + 1), 16'(16'h101 + i));
      if (i == 3) chk("ovf_pre", 32'(a_ovf), 0);
    end
    chk("ovf_set", 32'(a_ovf), 1);
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_name", a_tdata, 32'(i + 1));
      tick();
      chk("ovf_val", a_tdata, 32'(32'h101 + i));
      chk("ovf_last", 32'(a_tlast), 32'(i % 2));
      tick();
    end
    chk("ovf_no5th", 32'(a_tvalid), 0);
    chk("ovf_sticky", 32'(a_ovf), 1);
    do_rst();
    chk("ovf_clr", 32'(a_ovf), 0);

    // full FIFO with push and pop in the same cycle
    a_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      a_push(32'(11 + i), 16'(16'h21 + i));
    chk("fp_head", a_tdata, 11);
    a_ready = 1'b1;
    tick();
    chk("fp_v0", a_tdata, 32'h21);
    a_push(15, 16'h25);
    chk("fp_ovf", 32'(a_ovf), 0);
    chk("fp_count", 32'(ua.u_fifo.count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("fp_name", a_tdata, 32'(11 + i));
      tick();
      chk("fp_val", a_tdata, 32'(32'h21 + i));
      chk("fp_last", 32'(a_tlast), 32'(i % 2));
      tick();
    end
    chk("fp_idle", 32'(a_tvalid), 0);

    // narrow value zero-extension
    do_rst();
    a_ready = 1'b1;
    a_push(3, 16'hBEEF);
    tick();
    chk("nw_name", a_tdata, 3);
    tick();
    chk("nw_val", a_tdata, 32'h0000BEEF);
    tick();

    // reset mid-frame, K=3 (b) and K=1 (c)
    do_rst();
    b_ready = 1'b1;
    b_push(1, 32'h11);
    b_push(2, 32'h22);
    chk("mr_n0", b_tdata, 1);
    b_push(3, 32'h33);
    chk("mr_v0", b_tdata, 32'h11);
    chk("mr_bl0", 32'(b_tlast), 0);
    chk("mr_cl0", 32'(c_tlast), 1);
    tick();
    chk("mr_n1", b_tdata, 2);
    rst = 1'b1;
    #1;
    chk("mr_bvalid", 32'(b_tvalid), 0);
    chk("mr_cvalid", 32'(c_tvalid), 0);
    chk("mr_bdata", b_tdata, 0);
    tick();
    rst = 1'b0;
    chk("mr_flush", 32'(b_tvalid), 0);
    b_push(4, 32'h44);
    b_push(5, 32'h55);
    chk("mr_n4", b_tdata, 4);
    b_push(6, 32'h66);
    chk("mr_v4", b_tdata, 32'h44);
    chk("mr_bl4", 32'(b_tlast), 0);
    chk("mr_cl4", 32'(c_tlast), 1);
    tick();
    chk("mr_n5", b_tdata, 5);
    tick();
    chk("mr_v5", b_tdata, 32'h55);
    chk("mr_bl5", 32'(b_tlast), 0);
    tick();
    chk("mr_n6", b_tdata, 6);
    tick();
    chk("mr_v6", b_tdata, 32'h66);
    chk("mr_bl6", 32'(b_tlast), 1);
    chk("mr_cl6", 32'(c_tlast), 1);
    tick();
    chk("mr_idle", 32'(b_tvalid), 0);
    chk("mr_bovf", 32'(b_ovf), 0);
    chk("mr_covf", 32'(c_ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
